rpc_match_ctrl: RTL and testbench

//  Player-side controller that drives the rock-paper-scissors judge: collects one move per player
//  via valid/ready handshakes, presents both moves one-hot to the judge and samples its verdict.

---
 rtl/rpc_match_ctrl_if.sv | 20 ++
 rtl/rpc_match_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_rpc_match_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rpc_match_ctrl_if.sv
// Player-side move handshake bundle for the rock-paper-scissors match controller.
// The master offers moves, the slave (controller) accepts them.
interface rpc_match_ctrl_if;
    logic       a_valid;
    logic [1:0] a_move;
    logic       a_ready;
    logic       b_valid;
    logic [1:0] b_move;
    logic       b_ready;

    modport master (
        output a_valid, a_move, b_valid, b_move,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_move, b_valid, b_move,
        output a_ready, b_ready
    );
endinterface

// File: rtl/rpc_match_ctrl.sv
// Rock-paper-scissors match controller: collects both moves, drives the judge,
// scores verdicts, cross-checks the judge and declares the match result.
module rpc_match_ctrl #(
    parameter int WIN_TARGET = 3,
    parameter int MAX_ROUNDS = 9,
    parameter int SCORE_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    rpc_match_ctrl_if.slave    pl,
    output logic [2:0]         mv_a,
    output logic [2:0]         mv_b,
    input  logic               j_valid,
    input  logic               j_tie,
    input  logic               j_winA,
    input  logic               j_winB,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic [SCORE_W-1:0] rounds,
    output logic               busy,
    output logic               done,
    output logic               match_winA,
    output logic               match_winB,
    output logic               match_tie,
    output logic               round_err,
    output logic               judge_fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_JUDGE,
        S_DONE
    } state_t;

    localparam logic [SCORE_W-1:0] TGT = SCORE_W'(WIN_TARGET);
    localparam logic [SCORE_W-1:0] MAXR = SCORE_W'(MAX_ROUNDS);
    localparam logic [SCORE_W-1:0] ONE = SCORE_W'(1);

    state_t             r_state;
    state_t             w_next;
    logic               r_capA;
    logic               r_capB;
    logic [1:0]         r_movA;
    logic [1:0]         r_movB;
    logic [2:0]         r_mv_a;
    logic [2:0]         r_mv_b;
    logic [SCORE_W-1:0] r_score_a;
    logic [SCORE_W-1:0] r_score_b;
    logic [SCORE_W-1:0] r_rounds;
    logic               r_err;
    logic               r_fault;

    logic               w_start_ok;
    logic [1:0]         w_jcnt;
    logic               w_bad;
    logic               w_scored;
    logic [SCORE_W-1:0] w_sa_n;
    logic [SCORE_W-1:0] w_sb_n;
    logic [SCORE_W-1:0] w_rnd_n;
    logic               w_end;
    logic               w_exp_v;
    logic               w_exp_t;
    logic               w_exp_a;
    logic               w_exp_b;
    logic               w_mismatch;

    function automatic logic [2:0] onehot(input logic [1:0] m);
        logic [2:0] r;
        r = 3'b000;
        unique case (m)
            2'd0:    r = 3'b001;
            2'd1:    r = 3'b010;
            2'd2:    r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    always_comb begin
        w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
        w_jcnt     = {1'b0, j_tie} + {1'b0, j_winA} + {1'b0, j_winB};
        w_bad      = !j_valid || (j_winA && j_winB) || (w_jcnt > 2'd1);
        w_scored   = !w_bad && (j_winA || j_winB || j_tie);
        w_sa_n     = j_winA ? r_score_a + ONE : r_score_a;
        w_sb_n     = j_winB ? r_score_b + ONE : r_score_b;
        w_rnd_n    = r_rounds + ONE;
        w_end      = w_scored &&
                     (w_sa_n == TGT || w_sb_n == TGT || w_rnd_n == MAXR);
        // Reference outcome from the latched codes, for judging the judge
        w_exp_v    = (r_movA != 2'd3) && (r_movB != 2'd3);
        w_exp_t    = w_exp_v && (r_movA == r_movB);
        w_exp_a    = w_exp_v && ((r_movA == 2'd0 && r_movB == 2'd2) ||
                                 (r_movA == 2'd2 && r_movB == 2'd1) ||
                                 (r_movA == 2'd1 && r_movB == 2'd0));
        w_exp_b    = w_exp_v && ((r_movB == 2'd0 && r_movA == 2'd2) ||
                                 (r_movB == 2'd2 && r_movA == 2'd1) ||
                                 (r_movB == 2'd1 && r_movA == 2'd0));
        w_mismatch = {j_valid, j_tie, j_winA, j_winB} !=
                     {w_exp_v, w_exp_t, w_exp_a, w_exp_b};
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (start) w_next = S_COLLECT;
            S_COLLECT: if (r_capA && r_capB) w_next = S_JUDGE;
            S_JUDGE:   w_next = w_end ? S_DONE : S_COLLECT;
            S_DONE:    if (start) w_next = S_COLLECT;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_capA    <= 1'b0;
            r_capB    <= 1'b0;
            r_movA    <= 2'd0;
            r_movB    <= 2'd0;
            r_mv_a    <= 3'b000;
            r_mv_b    <= 3'b000;
            r_score_a <= '0;
            r_score_b <= '0;
            r_rounds  <= '0;
            r_err     <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= 1'b0;
            if (w_start_ok) begin
                r_capA    <= 1'b0;
                r_capB    <= 1'b0;
                r_score_a <= '0;
                r_score_b <= '0;
                r_rounds  <= '0;
                r_fault   <= 1'b0;
            end
            if (r_state == S_COLLECT) begin
                if (pl.a_valid && !r_capA) begin
                    r_capA <= 1'b1;
                    r_movA <= pl.a_move;
                end
                if (pl.b_valid && !r_capB) begin
                    r_capB <= 1'b1;
                    r_movB <= pl.b_move;
                end
            end
            r_mv_a <= (w_next == S_JUDGE) ? onehot(r_movA) : 3'b000;
            r_mv_b <= (w_next == S_JUDGE) ? onehot(r_movB) : 3'b000;
            if (r_state == S_JUDGE) begin
                r_capA <= 1'b0;
                r_capB <= 1'b0;
                if (w_mismatch) r_fault <= 1'b1;
                if (w_bad) begin
                    r_err <= 1'b1;
                end else if (w_scored) begin
                    r_score_a <= w_sa_n;
                    r_score_b <= w_sb_n;
                    r_rounds  <= w_rnd_n;
                end
            end
        end
    end

    assign pl.a_ready  = (r_state == S_COLLECT) && !r_capA;
    assign pl.b_ready  = (r_state == S_COLLECT) && !r_capB;
    assign mv_a        = r_mv_a;
    assign mv_b        = r_mv_b;
    assign score_a     = r_score_a;
    assign score_b     = r_score_b;
    assign rounds      = r_rounds;
    assign busy        = (r_state == S_COLLECT) || (r_state == S_JUDGE);
    assign done        = (r_state == S_DONE);
    assign match_winA  = done && (r_score_a > r_score_b);
    assign match_winB  = done && (r_score_b > r_score_a);
    assign match_tie   = done && (r_score_a == r_score_b);
    assign round_err   = r_err;
    assign judge_fault = r_fault;

endmodule

// File: tb/tb_rpc_match_ctrl.sv
// Bench for rpc_match_ctrl: scenario tasks plus randomized matches checked
// against a score/round model built from the game rules.
module tb_rpc_match_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] mv_a, mv_b;
    logic       j_valid, j_tie, j_winA, j_winB;
    logic [3:0] score_a, score_b, rounds;
    logic       busy, done, match_winA, match_winB, match_tie;
    logic       round_err, judge_fault;

    int n_vec = 0;
    int n_err = 0;
    int judge_mode = 0;
    int m_sa, m_sb, m_rnd;
    bit m_fault, m_done;

    always #5 clk = ~clk;

    rpc_match_ctrl_if pif ();

    rpc_match_ctrl #(.WIN_TARGET(3), .MAX_ROUNDS(9), .SCORE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pl(pif),
        .mv_a(mv_a), .mv_b(mv_b),
        .j_valid(j_valid), .j_tie(j_tie), .j_winA(j_winA), .j_winB(j_winB),
        .score_a(score_a), .score_b(score_b), .rounds(rounds),
        .busy(busy), .done(done), .match_winA(match_winA),
        .match_winB(match_winB), .match_tie(match_tie),
        .round_err(round_err), .judge_fault(judge_fault)
    );

    // {valid, tie, winA, winB}; mode 1 calls rock-vs-scissors a tie,
    // mode 2 claims both players won
    function automatic logic [3:0] verdict(int a, int b, int mode);
        if (a > 2 || b > 2) return 4'b0000;
        if (mode == 2) return 4'b1011;
        if (mode == 1 && a == 0 && b == 2) return 4'b1100;
        if (a == b) return 4'b1100;
        if ((a + 2) % 3 == b) return 4'b1010;
        return 4'b1001;
    endfunction

    function automatic int dec(logic [2:0] m);
        if (m == 3'b001) return 0;
        if (m == 3'b010) return 1;
        if (m == 3'b100) return 2;
        return 3;
    endfunction

    function automatic logic [2:0] oh(int m);
        logic [2:0] one;
        one = 3'b001;
        if (m > 2) return 3'b000;
        return one << m;
    endfunction

    always_comb begin
        {j_valid, j_tie, j_winA, j_winB} =
            verdict(dec(mv_a), dec(mv_b), judge_mode);
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_sa = 0; m_sb = 0; m_rnd = 0; m_fault = 0; m_done = 0;
        n_vec++;
        if ({score_a, score_b, rounds, busy, done, judge_fault,
             pif.a_ready, pif.b_ready} !== {12'd0, 3'b100, 2'b11}) begin
            n_err++;
            $display("FAIL start: got sa=%0d sb=%0d r=%0d busy=%b done=%b flt=%b rdy=%b%b",
                     score_a, score_b, rounds, busy, done, judge_fault,
                     pif.a_ready, pif.b_ready);
        end
    endtask

    task automatic do_round(input int ma, input int mb, input int gap);
        logic [3:0] jv, ev;
        bit bad, scored;
        n_vec++;
        if ({pif.a_ready, pif.b_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL ready_pre: got %b%b want 11", pif.a_ready, pif.b_ready);
        end
        pif.a_valid = 1'b1;
        pif.a_move  = 2'(ma);
        if (gap > 0) begin
            @(posedge clk); #1;
            pif.a_valid = 1'b0;
            pif.a_move  = 2'($urandom);
            n_vec++;
            if ({pif.a_ready, pif.b_ready, mv_a} !== 5'b01000) begin
                n_err++;
                $display("FAIL ready_stagger: got rdy=%b%b mv_a=%b want 01/000",
                         pif.a_ready, pif.b_ready, mv_a);
            end
            for (int i = 1; i < gap; i++) begin
                @(posedge clk); #1;
            end
        end
        pif.b_valid = 1'b1;
        pif.b_move  = 2'(mb);
        @(posedge clk); #1;
        pif.a_valid = 1'b0;
        pif.b_valid = 1'b0;
        n_vec++;
        if ({pif.a_ready, pif.b_ready, mv_a, mv_b, busy} !== 9'b00_000_000_1) begin
            n_err++;
            $display("FAIL captured: got rdy=%b%b mv=%b/%b busy=%b want 00 000/000 1",
                     pif.a_ready, pif.b_ready, mv_a, mv_b, busy);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({mv_a, mv_b, busy} !== {oh(ma), oh(mb), 1'b1}) begin
            n_err++;
            $display("FAIL judge_mv: got %b/%b busy=%b want %b/%b 1",
                     mv_a, mv_b, busy, oh(ma), oh(mb));
        end
        jv = verdict(ma, mb, judge_mode);
        ev = verdict(ma, mb, 0);
        if (jv != ev) m_fault = 1;
        bad = !jv[3] || (jv[1] && jv[0]) || (int'(jv[2]) + int'(jv[1]) + int'(jv[0]) > 1);
        scored = !bad && (jv[2:0] != 3'b000);
        if (scored) begin
            m_sa  += int'(jv[1]);
            m_sb  += int'(jv[0]);
            m_rnd += 1;
            m_done = (m_sa == 3) || (m_sb == 3) || (m_rnd == 9);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({score_a, score_b, rounds} !== {4'(m_sa), 4'(m_sb), 4'(m_rnd)}) begin
            n_err++;
            $display("FAIL score: got %0d/%0d r=%0d want %0d/%0d r=%0d",
                     score_a, score_b, rounds, m_sa, m_sb, m_rnd);
        end
        n_vec++;
        if ({round_err, judge_fault, done, busy, mv_a, mv_b} !==
            {bad, m_fault, m_done, !m_done, 6'b0}) begin
            n_err++;
            $display("FAIL flags: got err=%b flt=%b done=%b busy=%b mv=%b/%b want %b %b %b %b 000/000",
                     round_err, judge_fault, done, busy, mv_a, mv_b,
                     bad, m_fault, m_done, !m_done);
        end
        if (m_done) begin
            n_vec++;
            if ({match_winA, match_winB, match_tie} !==
                {m_sa > m_sb, m_sb > m_sa, m_sa == m_sb}) begin
                n_err++;
                $display("FAIL result: got wA=%b wB=%b t=%b want %b %b %b",
                         match_winA, match_winB, match_tie,
                         m_sa > m_sb, m_sb > m_sa, m_sa == m_sb);
            end
        end
    endtask

    task automatic test_reset();
        pif.a_valid = 1'b0; pif.b_valid = 1'b0;
        pif.a_move = 2'd0; pif.b_move = 2'd0;
        #12;
        n_vec++;
        if ({mv_a, mv_b, score_a, score_b, rounds, busy, done, match_winA,
             match_winB, match_tie, round_err, judge_fault,
             pif.a_ready, pif.b_ready} !== 27'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b sa=%0d mv=%b/%b rdy=%b%b want all 0",
                     busy, done, score_a, mv_a, mv_b, pif.a_ready, pif.b_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({busy, done, pif.a_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_hold: got busy=%b done=%b rdy=%b want 000",
                     busy, done, pif.a_ready);
        end
    endtask

    task automatic test_basic();
        do_start();
        do_round(1, 0, 0);
    endtask

    task automatic test_staggered();
        do_round(2, 2, 3);
    endtask

    task automatic test_illegal();
        do_round(3, 0, 0);
        do_round(0, 3, 1);
    endtask

    task automatic test_start_ignored();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++;
        if ({score_a, rounds, busy} !== {4'(m_sa), 4'(m_rnd), 1'b1}) begin
            n_err++;
            $display("FAIL start_ignored: got sa=%0d r=%0d busy=%b want %0d %0d 1",
                     score_a, rounds, busy, m_sa, m_rnd);
        end
    endtask

    task automatic test_win();
        for (int i = 0; i < 6 && !m_done; i++) do_round(2, 1, 0);
        n_vec++;
        if ({done, match_winA, busy, score_a} !== {3'b110, 4'd3}) begin
            n_err++;
            $display("FAIL win_match: got done=%b wA=%b busy=%b sa=%0d want 1 1 0 3",
                     done, match_winA, busy, score_a);
        end
        do_start();
    endtask

    task automatic test_tie_match();
        int sa[9] = '{1, 2, 0, 2, 1, 2, 0, 2, 2};
        int sb[9] = '{0, 2, 1, 2, 0, 2, 1, 2, 2};
        for (int i = 0; i < 9; i++) do_round(sa[i], sb[i], 0);
        n_vec++;
        if ({done, match_tie, rounds, score_a, score_b} !==
            {2'b11, 4'd9, 4'd2, 4'd2}) begin
            n_err++;
            $display("FAIL tie_match: got done=%b t=%b r=%0d %0d-%0d want 1 1 9 2-2",
                     done, match_tie, rounds, score_a, score_b);
        end
        do_start();
    endtask

    task automatic test_judge_fault();
        judge_mode = 1;
        do_round(0, 2, 0);
        judge_mode = 0;
        do_round(1, 0, 0);
        n_vec++;
        if ({judge_fault, score_a, rounds} !== {1'b1, 4'd1, 4'd2}) begin
            n_err++;
            $display("FAIL fault_sticky: got flt=%b sa=%0d r=%0d want 1 1 2",
                     judge_fault, score_a, rounds);
        end
        pif.a_valid = 1'b1; pif.a_move = 2'd1;
        pif.b_valid = 1'b1; pif.b_move = 2'd1;
        @(posedge clk); #1;
        pif.a_valid = 1'b0; pif.b_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({mv_a, mv_b} !== 6'b010_010) begin
            n_err++;
            $display("FAIL mid_judge_mv: got %b/%b want 010/010", mv_a, mv_b);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({mv_a, mv_b, score_a, score_b, rounds, busy, done, match_winA,
             match_winB, match_tie, round_err, judge_fault,
             pif.a_ready, pif.b_ready} !== 27'd0) begin
            n_err++;
            $display("FAIL reset_in_judge: got mv=%b/%b sa=%0d r=%0d busy=%b flt=%b want all 0",
                     mv_a, mv_b, score_a, rounds, busy, judge_fault);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_start();
    endtask

    task automatic test_random();
        for (int m = 0; m < 4; m++) begin
            for (int r = 0; r < 60 && !m_done; r++) begin
                judge_mode = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
                do_round(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 2)));
            end
            judge_mode = 0;
            if (!m_done) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
            end
            do_start();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_staggered();
        test_illegal();
        test_start_ignored();
        test_win();
        test_tie_match();
        test_judge_fault();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
